// File: rtl/ppu_timing_gen_pkg.sv
// ppu_timing_gen_pkg: PPU mode encoding, register types and DMG default timing
package ppu_timing_gen_pkg;
  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    DRAW     = 2'd3
  } ppu_phase_t;
  typedef struct packed {
    logic ena;
    logic win_map;
    logic win_ena;
    logic tile_sel;
    logic bg_map;
    logic obj_size;
    logic obj_ena;
    logic bg_ena;
  } lcdc_t;
  typedef enum logic [3:0] {
    REG_LCDC, REG_STAT, REG_SCY, REG_SCX, REG_LY, REG_LYC,
    REG_DMA, REG_BGP, REG_OBP0, REG_OBP1, REG_WY, REG_WX
  } ppu_reg_t;
  localparam int DMG_DOTS_PER_LINE = 456;
  localparam int DMG_VISIBLE_LINES = 144;
  localparam int DMG_TOTAL_LINES   = 154;
  localparam int DMG_OAM_DOTS      = 80;
  localparam int DMG_MAX_DRAW_DOTS = 289;
endpackage

// File: rtl/ppu_timing_gen_if.sv
// ppu_timing_gen_if: control inputs and timing outputs of the PPU timing generator
interface ppu_timing_gen_if #(parameter int DOTS_PER_LINE = 456);
  import ppu_timing_gen_pkg::*;
  localparam int DW = $clog2(DOTS_PER_LINE);
  logic          ena;
  logic [7:0]    lyc;
  logic [3:0]    stat_sel;
  logic          draw_done;
  logic [7:0]    ly;
  logic [DW-1:0] dot;
  ppu_phase_t    phase;
  logic          lyc_eq;
  logic          line_start;
  logic          irq_vblank;
  logic          irq_stat;
  logic          lcd_hsync;
  logic          lcd_vsync;
  logic          lcd_de;
  modport master (
    output ena, lyc, stat_sel, draw_done,
    input  ly, dot, phase, lyc_eq, line_start, irq_vblank, irq_stat, lcd_hsync, lcd_vsync, lcd_de
  );
  modport slave (
    input  ena, lyc, stat_sel, draw_done,
    output ly, dot, phase, lyc_eq, line_start, irq_vblank, irq_stat, lcd_hsync, lcd_vsync, lcd_de
  );
endinterface

// File: rtl/ppu_timing_gen_stat_irq.sv
// ppu_stat_irq: STAT source mux with per-source enables and rising-edge interrupt
module ppu_stat_irq
  import ppu_timing_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  ppu_phase_t i_phase,
  input  logic       i_lyc_eq,
  input  logic [3:0] i_sel,
  output logic       o_irq
);
  logic w_line;
  logic r_line;
  logic r_irq;
  // STAT line for the coming cycle; forced low while the generator is idle
  always_comb w_line = !i_clr && ((i_phase == HBLANK && i_sel[0]) || (i_phase == VBLANK && i_sel[1]) ||
                                  (i_phase == OAM_SCAN && i_sel[2]) || (i_lyc_eq && i_sel[3]));
  // only a 0->1 transition of the merged line raises the interrupt
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_line <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_line <= w_line;
      r_irq  <= w_line && !r_line;
    end
  assign o_irq = r_irq;
endmodule

// File: rtl/ppu_timing_gen.sv
// ppu_timing_gen: scanline/frame mode sequencer with LY compare, interrupts and LCD strobes
module ppu_timing_gen
  import ppu_timing_gen_pkg::*;
#(
  parameter int DOTS_PER_LINE = DMG_DOTS_PER_LINE,
  parameter int VISIBLE_LINES = DMG_VISIBLE_LINES,
  parameter int TOTAL_LINES   = DMG_TOTAL_LINES,
  parameter int OAM_DOTS      = DMG_OAM_DOTS,
  parameter int MAX_DRAW_DOTS = DMG_MAX_DRAW_DOTS,
  parameter int HSYNC_START   = 400,
  parameter int HSYNC_LEN     = 8,
  parameter int VSYNC_LINE    = 153
) (
  input logic             clk,
  input logic             rst_n,
  ppu_timing_gen_if.slave io_tg
);
  localparam int DW = $clog2(DOTS_PER_LINE);
  localparam int DW1 = DW + 1;
  localparam logic [DW-1:0] LAST_DOT = DW'(DOTS_PER_LINE - 1);
  localparam logic [DW-1:0] DRAW_DOT = DW'(OAM_DOTS);
  localparam logic [DW-1:0] DRAW_END = DW'(OAM_DOTS + MAX_DRAW_DOTS);
  localparam logic [DW:0]   HS_BEG   = DW1'(HSYNC_START);
  localparam logic [DW:0]   HS_END   = DW1'(HSYNC_START + HSYNC_LEN);
  localparam logic [7:0]    LAST_LY  = 8'(TOTAL_LINES - 1);
  localparam logic [7:0]    VIS_LY   = 8'(VISIBLE_LINES);
  localparam logic [7:0]    VS_LY    = 8'(VSYNC_LINE);
  if (OAM_DOTS + MAX_DRAW_DOTS >= DOTS_PER_LINE) begin : g_bad_draw
    $error("OAM_DOTS + MAX_DRAW_DOTS must be below DOTS_PER_LINE");
  end
  if (TOTAL_LINES > 256) begin : g_bad_lines
    $error("TOTAL_LINES must not exceed 256");
  end
  logic [DW-1:0] r_dot, w_dot_nx;
  logic [7:0]    r_ly, w_ly_nx;
  ppu_phase_t    r_phase, w_phase_nx;
  logic          r_run, w_run_nx, w_idle, w_wrap;
  logic          r_lyc_eq, r_line_start, r_irq_vblank, r_hsync, r_vsync, r_de;
  logic          w_lyc_eq_nx, w_line_start_nx, w_irq_vblank_nx, w_hsync_nx, w_vsync_nx, w_de_nx;
  // state register: counters, mode and the registered strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_dot        <= '0;
      r_ly         <= '0;
      r_phase      <= HBLANK;
      r_run        <= 1'b0;
      r_lyc_eq     <= 1'b0;
      r_line_start <= 1'b0;
      r_irq_vblank <= 1'b0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_de         <= 1'b0;
    end else begin
      r_dot        <= w_dot_nx;
      r_ly         <= w_ly_nx;
      r_phase      <= w_phase_nx;
      r_run        <= w_run_nx;
      r_lyc_eq     <= w_lyc_eq_nx;
      r_line_start <= w_line_start_nx;
      r_irq_vblank <= w_irq_vblank_nx;
      r_hsync      <= w_hsync_nx;
      r_vsync      <= w_vsync_nx;
      r_de         <= w_de_nx;
    end
  // next state: idle when disabled, restart at line 0 on enable, otherwise advance dot/line and mode
  always_comb begin
    w_idle     = !io_tg.ena;
    w_wrap     = r_dot == LAST_DOT;
    w_run_nx   = io_tg.ena;
    w_dot_nx   = (w_idle || !r_run || w_wrap) ? '0 : r_dot + DW'(1);
    w_ly_nx    = (w_idle || !r_run || (w_wrap && r_ly == LAST_LY)) ? '0 : r_ly + {7'd0, w_wrap};
    w_phase_nx = w_idle                 ? HBLANK
               : w_ly_nx >= VIS_LY      ? VBLANK
               : w_dot_nx == '0         ? OAM_SCAN
               : w_dot_nx == DRAW_DOT   ? DRAW
               : (r_phase == DRAW && (io_tg.draw_done || w_dot_nx == DRAW_END)) ? HBLANK
               : r_phase;
  end
  // strobes are derived from the next dot/line/mode so they describe the same cycle
  always_comb begin
    w_lyc_eq_nx     = !w_idle && w_ly_nx == io_tg.lyc;
    w_line_start_nx = !w_idle && w_dot_nx == '0;
    w_irq_vblank_nx = w_line_start_nx && w_ly_nx == VIS_LY;
    w_hsync_nx      = !w_idle && {1'b0, w_dot_nx} >= HS_BEG && {1'b0, w_dot_nx} < HS_END;
    w_vsync_nx      = !w_idle && w_ly_nx == VS_LY;
    w_de_nx         = w_phase_nx == DRAW;
  end
  ppu_stat_irq u_stat (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_idle),
    .i_phase  (w_phase_nx),
    .i_lyc_eq (w_lyc_eq_nx),
    .i_sel    (io_tg.stat_sel),
    .o_irq    (io_tg.irq_stat)
  );
  assign io_tg.dot        = r_dot;
  assign io_tg.ly         = r_ly;
  assign io_tg.phase      = r_phase;
  assign io_tg.lyc_eq     = r_lyc_eq;
  assign io_tg.line_start = r_line_start;
  assign io_tg.irq_vblank = r_irq_vblank;
  assign io_tg.lcd_hsync  = r_hsync;
  assign io_tg.lcd_vsync  = r_vsync;
  assign io_tg.lcd_de     = r_de;
endmodule

// File: tb/tb_ppu_timing_gen.sv
// tb_ppu_timing_gen: directed DMG-timing scenarios plus a randomized small-parameter run against a reference model
module tb_ppu_timing_gen;
  import ppu_timing_gen_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int a_t = 0;
  always #5 clk = ~clk;
  ppu_timing_gen_if a_if ();
  ppu_timing_gen_if #(.DOTS_PER_LINE(100)) b_if ();
  ppu_timing_gen u_a (.clk(clk), .rst_n(rst_n), .io_tg(a_if.slave));
  ppu_timing_gen #(
    .DOTS_PER_LINE(100), .VISIBLE_LINES(8), .TOTAL_LINES(10), .OAM_DOTS(10), .MAX_DRAW_DOTS(40),
    .HSYNC_START(80), .HSYNC_LEN(5), .VSYNC_LINE(9)
  ) u_b (.clk(clk), .rst_n(rst_n), .io_tg(b_if.slave));

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      a_t++;
    end
  endtask

  task automatic test_reset();
    a_if.ena = 1'b0; a_if.lyc = 8'd0; a_if.stat_sel = 4'hf; a_if.draw_done = 1'b0;
    b_if.ena = 1'b0; b_if.lyc = 8'd0; b_if.stat_sel = 4'hf; b_if.draw_done = 1'b0;
    rst_n = 1'b0;
    adv(3);
    checks++; if (a_if.dot !== 9'd0) begin failures++; $display("FAIL rst_dot got=%0d exp=0", a_if.dot); end
    checks++; if (a_if.ly !== 8'd0) begin failures++; $display("FAIL rst_ly got=%0d exp=0", a_if.ly); end
    checks++; if (a_if.phase !== HBLANK) begin failures++; $display("FAIL rst_phase got=%0d exp=%0d", a_if.phase, HBLANK); end
    checks++; if (a_if.lyc_eq !== 1'b0) begin failures++; $display("FAIL rst_lyc_eq got=%0b exp=0", a_if.lyc_eq); end
    checks++; if ({a_if.line_start, a_if.irq_vblank, a_if.irq_stat, a_if.lcd_hsync, a_if.lcd_vsync, a_if.lcd_de} !== 6'b0)
      begin failures++; $display("FAIL rst_strobes got=%b exp=000000", {a_if.line_start, a_if.irq_vblank, a_if.irq_stat, a_if.lcd_hsync, a_if.lcd_vsync, a_if.lcd_de}); end
    rst_n = 1'b1;
    adv(3);
    checks++; if (a_if.lyc_eq !== 1'b0) begin failures++; $display("FAIL idle_lyc_eq got=%0b exp=0", a_if.lyc_eq); end
    checks++; if (a_if.irq_stat !== 1'b0) begin failures++; $display("FAIL idle_irq_stat got=%0b exp=0", a_if.irq_stat); end
    checks++; if (b_if.phase !== HBLANK || b_if.dot !== 7'd0) begin failures++; $display("FAIL idle_b got phase=%0d dot=%0d exp phase=0 dot=0", b_if.phase, b_if.dot); end
  endtask

  task automatic test_line();
    a_if.stat_sel = 4'h0; a_if.lyc = 8'd200; a_if.ena = 1'b1;
    adv(1);
    a_t = 0;
    checks++; if (a_if.dot !== 9'd0 || a_if.ly !== 8'd0) begin failures++; $display("FAIL en_pos got dot=%0d ly=%0d exp 0/0", a_if.dot, a_if.ly); end
    checks++; if (a_if.phase !== OAM_SCAN) begin failures++; $display("FAIL en_phase got=%0d exp=%0d", a_if.phase, OAM_SCAN); end
    checks++; if (a_if.line_start !== 1'b1) begin failures++; $display("FAIL en_line_start got=%0b exp=1", a_if.line_start); end
    adv(79);
    checks++; if (a_if.phase !== OAM_SCAN) begin failures++; $display("FAIL oam_end got=%0d exp=%0d", a_if.phase, OAM_SCAN); end
    adv(1);
    checks++; if (a_if.phase !== DRAW || a_if.lcd_de !== 1'b1) begin failures++; $display("FAIL draw_start got phase=%0d de=%0b exp 3/1", a_if.phase, a_if.lcd_de); end
    adv(171);
    checks++; if (a_if.dot !== 9'd251 || a_if.phase !== DRAW) begin failures++; $display("FAIL dot251 got dot=%0d phase=%0d exp 251/3", a_if.dot, a_if.phase); end
    a_if.draw_done = 1'b1;
    adv(1);
    a_if.draw_done = 1'b0;
    checks++; if (a_if.dot !== 9'd252 || a_if.phase !== HBLANK || a_if.lcd_de !== 1'b0)
      begin failures++; $display("FAIL draw_done_end got dot=%0d phase=%0d de=%0b exp 252/0/0", a_if.dot, a_if.phase, a_if.lcd_de); end
    adv(147);
    checks++; if (a_if.lcd_hsync !== 1'b0) begin failures++; $display("FAIL hsync399 got=%0b exp=0", a_if.lcd_hsync); end
    adv(1);
    checks++; if (a_if.lcd_hsync !== 1'b1) begin failures++; $display("FAIL hsync400 got=%0b exp=1", a_if.lcd_hsync); end
    adv(7);
    checks++; if (a_if.lcd_hsync !== 1'b1) begin failures++; $display("FAIL hsync407 got=%0b exp=1", a_if.lcd_hsync); end
    adv(1);
    checks++; if (a_if.lcd_hsync !== 1'b0) begin failures++; $display("FAIL hsync408 got=%0b exp=0", a_if.lcd_hsync); end
    adv(47);
    checks++; if (a_if.dot !== 9'd455 || a_if.ly !== 8'd0 || a_if.line_start !== 1'b0)
      begin failures++; $display("FAIL dot455 got dot=%0d ly=%0d ls=%0b exp 455/0/0", a_if.dot, a_if.ly, a_if.line_start); end
    adv(1);
    checks++; if (a_if.dot !== 9'd0 || a_if.ly !== 8'd1 || a_if.line_start !== 1'b1 || a_if.phase !== OAM_SCAN)
      begin failures++; $display("FAIL wrap got dot=%0d ly=%0d ls=%0b phase=%0d exp 0/1/1/2", a_if.dot, a_if.ly, a_if.line_start, a_if.phase); end
  endtask

  task automatic test_timeout();
    adv(40);
    a_if.draw_done = 1'b1;
    adv(1);
    a_if.draw_done = 1'b0;
    adv(39);
    checks++; if (a_if.dot !== 9'd80 || a_if.phase !== DRAW) begin failures++; $display("FAIL oam_done_ignored got dot=%0d phase=%0d exp 80/3", a_if.dot, a_if.phase); end
    adv(288);
    checks++; if (a_if.phase !== DRAW) begin failures++; $display("FAIL draw368 got=%0d exp=%0d", a_if.phase, DRAW); end
    adv(1);
    checks++; if (a_if.dot !== 9'd369 || a_if.phase !== HBLANK) begin failures++; $display("FAIL timeout369 got dot=%0d phase=%0d exp 369/0", a_if.dot, a_if.phase); end
  endtask

  task automatic test_lyc_stat();
    int n_irq = 0;
    int n_eq = 0;
    a_if.lyc = 8'd5; a_if.stat_sel = 4'b1000;
    while (a_t < 5 * 456 - 1) begin
      adv(1);
      if (a_if.irq_stat) n_irq++;
      if (a_if.lyc_eq) n_eq++;
    end
    checks++; if (n_irq != 0 || n_eq != 0) begin failures++; $display("FAIL lyc_before got irq=%0d eq=%0d exp 0/0", n_irq, n_eq); end
    adv(1);
    checks++; if (a_if.ly !== 8'd5 || a_if.lyc_eq !== 1'b1 || a_if.irq_stat !== 1'b1)
      begin failures++; $display("FAIL lyc_hit got ly=%0d eq=%0b irq=%0b exp 5/1/1", a_if.ly, a_if.lyc_eq, a_if.irq_stat); end
    n_irq = 0; n_eq = 0;
    while (a_t < 5 * 456 + 380) begin
      adv(1);
      if (a_if.irq_stat) n_irq++;
      if (!a_if.lyc_eq) n_eq++;
    end
    checks++; if (n_irq != 0 || n_eq != 0 || a_if.phase !== HBLANK)
      begin failures++; $display("FAIL lyc_hold got irq=%0d eq_low=%0d phase=%0d exp 0/0/0", n_irq, n_eq, a_if.phase); end
    a_if.stat_sel = 4'b1001;
    n_irq = 0;
    while (a_t < 6 * 456 - 1) begin
      adv(1);
      if (a_if.irq_stat) n_irq++;
      if (!a_if.lyc_eq) n_eq++;
    end
    checks++; if (n_irq != 0 || n_eq != 0) begin failures++; $display("FAIL stat_block got irq=%0d eq_low=%0d exp 0/0", n_irq, n_eq); end
    adv(1);
    checks++; if (a_if.ly !== 8'd6 || a_if.lyc_eq !== 1'b0 || a_if.irq_stat !== 1'b0)
      begin failures++; $display("FAIL lyc_leave got ly=%0d eq=%0b irq=%0b exp 6/0/0", a_if.ly, a_if.lyc_eq, a_if.irq_stat); end
    a_if.stat_sel = 4'b0000;
    adv(400);
    checks++; if (a_if.phase !== HBLANK || a_if.irq_stat !== 1'b0) begin failures++; $display("FAIL sel_pre got phase=%0d irq=%0b exp 0/0", a_if.phase, a_if.irq_stat); end
    a_if.stat_sel = 4'b0001;
    adv(1);
    checks++; if (a_if.irq_stat !== 1'b1) begin failures++; $display("FAIL sel_raise got=%0b exp=1", a_if.irq_stat); end
    adv(1);
    checks++; if (a_if.irq_stat !== 1'b0) begin failures++; $display("FAIL sel_pulse_width got=%0b exp=0", a_if.irq_stat); end
    a_if.stat_sel = 4'b0000; a_if.lyc = 8'd200;
  endtask

  task automatic test_vblank_frame();
    int n_vb = 0;
    int n_vs = 0;
    while (a_t < 65664 - 1) begin
      adv(1);
      if (a_if.irq_vblank) n_vb++;
    end
    checks++; if (n_vb != 0) begin failures++; $display("FAIL vblank_early got=%0d exp=0", n_vb); end
    adv(1);
    checks++; if (a_if.irq_vblank !== 1'b1 || a_if.ly !== 8'd144 || a_if.phase !== VBLANK || a_if.dot !== 9'd0)
      begin failures++; $display("FAIL vblank_entry got irq=%0b ly=%0d phase=%0d dot=%0d exp 1/144/1/0", a_if.irq_vblank, a_if.ly, a_if.phase, a_if.dot); end
    n_vb = 0;
    while (a_t < 153 * 456 - 1) begin
      adv(1);
      if (a_if.irq_vblank) n_vb++;
      if (a_if.lcd_vsync) n_vs++;
    end
    checks++; if (n_vb != 0 || n_vs != 0) begin failures++; $display("FAIL vblank_body got vb=%0d vs=%0d exp 0/0", n_vb, n_vs); end
    adv(1);
    checks++; if (a_if.ly !== 8'd153 || a_if.lcd_vsync !== 1'b1 || a_if.phase !== VBLANK)
      begin failures++; $display("FAIL vsync_start got ly=%0d vs=%0b phase=%0d exp 153/1/1", a_if.ly, a_if.lcd_vsync, a_if.phase); end
    n_vs = 0;
    while (a_t < 70224 - 1) begin
      adv(1);
      if (!a_if.lcd_vsync || a_if.irq_vblank) n_vs++;
    end
    checks++; if (n_vs != 0) begin failures++; $display("FAIL vsync_line got bad_cycles=%0d exp=0", n_vs); end
    adv(1);
    checks++; if (a_if.ly !== 8'd0 || a_if.dot !== 9'd0 || a_if.phase !== OAM_SCAN || a_if.line_start !== 1'b1 || a_if.lcd_vsync !== 1'b0)
      begin failures++; $display("FAIL frame_wrap got ly=%0d dot=%0d phase=%0d ls=%0b vs=%0b exp 0/0/2/1/0", a_if.ly, a_if.dot, a_if.phase, a_if.line_start, a_if.lcd_vsync); end
  endtask

  task automatic test_ena_drop();
    int n_irq = 0;
    adv(456 + 200);
    checks++; if (a_if.ly !== 8'd1 || a_if.dot !== 9'd200 || a_if.phase !== DRAW)
      begin failures++; $display("FAIL pre_drop got ly=%0d dot=%0d phase=%0d exp 1/200/3", a_if.ly, a_if.dot, a_if.phase); end
    a_if.stat_sel = 4'b1001; a_if.lyc = 8'd0; a_if.ena = 1'b0;
    adv(1);
    checks++; if (a_if.ly !== 8'd0 || a_if.dot !== 9'd0 || a_if.phase !== HBLANK || a_if.lyc_eq !== 1'b0)
      begin failures++; $display("FAIL drop_idle got ly=%0d dot=%0d phase=%0d eq=%0b exp 0/0/0/0", a_if.ly, a_if.dot, a_if.phase, a_if.lyc_eq); end
    checks++; if ({a_if.line_start, a_if.irq_vblank, a_if.irq_stat, a_if.lcd_hsync, a_if.lcd_vsync, a_if.lcd_de} !== 6'b0)
      begin failures++; $display("FAIL drop_strobes got=%b exp=000000", {a_if.line_start, a_if.irq_vblank, a_if.irq_stat, a_if.lcd_hsync, a_if.lcd_vsync, a_if.lcd_de}); end
    for (int i = 0; i < 5; i++) begin
      adv(1);
      if (a_if.irq_stat || a_if.irq_vblank) n_irq++;
    end
    checks++; if (n_irq != 0) begin failures++; $display("FAIL drop_quiet got=%0d exp=0", n_irq); end
    a_if.stat_sel = 4'h0; a_if.lyc = 8'd200;
  endtask

  task automatic test_async_reset();
    a_if.ena = 1'b1;
    adv(1);
    checks++; if (a_if.phase !== OAM_SCAN || a_if.line_start !== 1'b1) begin failures++; $display("FAIL reen got phase=%0d ls=%0b exp 2/1", a_if.phase, a_if.line_start); end
    adv(100);
    checks++; if (a_if.phase !== DRAW || a_if.dot !== 9'd100) begin failures++; $display("FAIL pre_rst got phase=%0d dot=%0d exp 3/100", a_if.phase, a_if.dot); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_if.phase !== HBLANK || a_if.dot !== 9'd0 || a_if.ly !== 8'd0 || a_if.lcd_de !== 1'b0)
      begin failures++; $display("FAIL async_rst got phase=%0d dot=%0d ly=%0d de=%0b exp 0/0/0/0", a_if.phase, a_if.dot, a_if.ly, a_if.lcd_de); end
    a_if.ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    adv(2);
  endtask

  task automatic test_random_small();
    int t = -1;
    int dend = 50;
    int e_dot = 0;
    int e_ly = 0;
    int p_lyc;
    logic [3:0] p_sel;
    logic p_line = 1'b0;
    logic e_line;
    ppu_phase_t e_ph = HBLANK;
    b_if.lyc = 8'd0; b_if.stat_sel = 4'h0; b_if.draw_done = 1'b0; b_if.ena = 1'b1;
    for (int c = 0; c < 2600; c++) begin
      p_lyc = int'(b_if.lyc);
      p_sel = b_if.stat_sel;
      if (e_ph == DRAW && b_if.draw_done) dend = e_dot + 1;
      adv(1);
      t++;
      e_dot = t % 100;
      e_ly = (t / 100) % 10;
      if (e_dot == 0) dend = 50;
      e_ph = e_ly >= 8 ? VBLANK : e_dot < 10 ? OAM_SCAN : e_dot < dend ? DRAW : HBLANK;
      e_line = (e_ph == HBLANK && p_sel[0]) || (e_ph == VBLANK && p_sel[1]) || (e_ph == OAM_SCAN && p_sel[2]) || (e_ly == p_lyc && p_sel[3]);
      checks++; if (b_if.dot !== 7'(e_dot)) begin failures++; $display("FAIL rnd_dot t=%0d got=%0d exp=%0d", t, b_if.dot, e_dot); end
      checks++; if (b_if.ly !== 8'(e_ly)) begin failures++; $display("FAIL rnd_ly t=%0d got=%0d exp=%0d", t, b_if.ly, e_ly); end
      checks++; if (b_if.phase !== e_ph) begin failures++; $display("FAIL rnd_phase t=%0d got=%0d exp=%0d", t, b_if.phase, e_ph); end
      checks++; if (b_if.lyc_eq !== (e_ly == p_lyc)) begin failures++; $display("FAIL rnd_lyc_eq t=%0d got=%0b exp=%0b", t, b_if.lyc_eq, e_ly == p_lyc); end
      checks++; if (b_if.line_start !== (e_dot == 0)) begin failures++; $display("FAIL rnd_line_start t=%0d got=%0b exp=%0b", t, b_if.line_start, e_dot == 0); end
      checks++; if (b_if.irq_vblank !== (e_dot == 0 && e_ly == 8)) begin failures++; $display("FAIL rnd_irq_vblank t=%0d got=%0b exp=%0b", t, b_if.irq_vblank, e_dot == 0 && e_ly == 8); end
      checks++; if (b_if.irq_stat !== (e_line && !p_line)) begin failures++; $display("FAIL rnd_irq_stat t=%0d got=%0b exp=%0b", t, b_if.irq_stat, e_line && !p_line); end
      checks++; if (b_if.lcd_hsync !== (e_dot >= 80 && e_dot < 85)) begin failures++; $display("FAIL rnd_hsync t=%0d got=%0b exp=%0b", t, b_if.lcd_hsync, e_dot >= 80 && e_dot < 85); end
      checks++; if (b_if.lcd_vsync !== (e_ly == 9)) begin failures++; $display("FAIL rnd_vsync t=%0d got=%0b exp=%0b", t, b_if.lcd_vsync, e_ly == 9); end
      checks++; if (b_if.lcd_de !== (e_ph == DRAW)) begin failures++; $display("FAIL rnd_de t=%0d got=%0b exp=%0b", t, b_if.lcd_de, e_ph == DRAW); end
      p_line = e_line;
      b_if.draw_done = ($urandom_range(7) == 0);
      if ($urandom_range(49) == 0) b_if.lyc = 8'($urandom_range(11));
      if ($urandom_range(29) == 0) b_if.stat_sel = 4'($urandom_range(15));
    end
    b_if.ena = 1'b0;
    adv(1);
    checks++; if (b_if.phase !== HBLANK || b_if.dot !== 7'd0 || b_if.irq_stat !== 1'b0)
      begin failures++; $display("FAIL rnd_idle got phase=%0d dot=%0d irq=%0b exp 0/0/0", b_if.phase, b_if.dot, b_if.irq_stat); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_timeout();
    test_lyc_stat();
    test_vblank_frame();
    test_ena_drop();
    test_async_reset();
    test_random_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
